// File: rtl/draw_cell_overlay.sv
// draw_cell_overlay: board overlay (owner fills, cursor border, blinking win cells) with 2-cycle pipeline
module draw_cell_overlay #(
  parameter int          GRID_X0      = 0,
  parameter int          GRID_Y0      = 10,
  parameter int          CELL_W       = 341,
  parameter int          CELL_H       = 249,
  parameter int          COLS         = 3,
  parameter int          ROWS         = 3,
  parameter int          BORDER       = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] COLOR_P0     = 12'h00f,
  parameter logic [11:0] COLOR_P1     = 12'hff0,
  parameter logic [11:0] COLOR_CUR    = 12'h0f0
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [10:0]             hcount_in,
  input  logic                    hsync_in,
  input  logic                    hblnk_in,
  input  logic [10:0]             vcount_in,
  input  logic                    vsync_in,
  input  logic                    vblnk_in,
  input  logic [11:0]             rgb_in,
  input  logic                    start_en,
  input  logic                    choice_en,
  input  logic [ROWS*COLS-1:0]    cell_occ,
  input  logic [ROWS*COLS-1:0]    cell_owner,
  input  logic [ROWS*COLS-1:0]    win_mask,
  input  logic                    cursor_en,
  input  logic [3:0]              cursor_idx,
  output logic [10:0]             hcount_out,
  output logic                    hsync_out,
  output logic                    hblnk_out,
  output logic [10:0]             vcount_out,
  output logic                    vsync_out,
  output logic                    vblnk_out,
  output logic [11:0]             rgb_out
);
  localparam int N  = ROWS * COLS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic          vsync_q, vs_rise, last_frame;
  logic [N-1:0]  occ_q, own_q, win_q;
  logic          cur_en_q;
  logic [3:0]    cur_idx_q;
  logic [FW-1:0] frame_q;
  logic          blink_q;
  assign vs_rise    = vsync_in & ~vsync_q;
  assign last_frame = frame_q == FW'(BLINK_FRAMES - 1);
  // board state and blink timer only move at frame start so a frame never tears
  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      occ_q     <= '0;
      own_q     <= '0;
      win_q     <= '0;
      cur_en_q  <= 1'b0;
      cur_idx_q <= '0;
      frame_q   <= '0;
      blink_q   <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      if (vs_rise) begin
        occ_q     <= cell_occ;
        own_q     <= cell_owner;
        win_q     <= win_mask;
        cur_en_q  <= cursor_en;
        cur_idx_q <= cursor_idx;
        frame_q   <= last_frame ? '0 : frame_q + 1'b1;
        blink_q   <= blink_q ^ last_frame;
      end
    end
  end
  logic [12:0]   dx, dy, xo, yo;
  int            col, row;
  logic          in_grid, border_d, pass_d;
  logic [IW-1:0] idx_d;
  // 13-bit offsets: bit 12 set means the pixel lies left of / above the grid
  always_comb begin
    dx  = {2'b0, hcount_in} - 13'(GRID_X0);
    dy  = {2'b0, vcount_in} - 13'(GRID_Y0);
    col = 0;
    row = 0;
    xo  = dx;
    yo  = dy;
    for (int c = 1; c < COLS; c++)
      if (dx >= 13'(c * CELL_W)) begin
        col = c;
        xo  = dx - 13'(c * CELL_W);
      end
    for (int r = 1; r < ROWS; r++)
      if (dy >= 13'(r * CELL_H)) begin
        row = r;
        yo  = dy - 13'(r * CELL_H);
      end
    in_grid  = !dx[12] && dx < 13'(COLS * CELL_W) && !dy[12] && dy < 13'(ROWS * CELL_H);
    border_d = xo <= 13'(BORDER) || xo >= 13'(CELL_W - 1 - BORDER) ||
               yo <= 13'(BORDER) || yo >= 13'(CELL_H - 1 - BORDER);
    idx_d    = IW'(row * COLS + col);
    pass_d   = hblnk_in | vblnk_in | ~start_en | choice_en | ~in_grid;
  end
  logic [10:0]   hcount_q, vcount_q;
  logic          hsync_q, hblnk_q, vsync1_q, vblnk_q, pass_q, border_q;
  logic [11:0]   rgb_q, rgb_d;
  logic [IW-1:0] idx_q;
  logic          hit_cur;
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vcount_q <= '0;
      vsync1_q <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
      pass_q   <= 1'b1;
      border_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      hcount_q <= hcount_in;
      hsync_q  <= hsync_in;
      hblnk_q  <= hblnk_in;
      vcount_q <= vcount_in;
      vsync1_q <= vsync_in;
      vblnk_q  <= vblnk_in;
      rgb_q    <= rgb_in;
      pass_q   <= pass_d;
      border_q <= border_d;
      idx_q    <= idx_d;
    end
  end
  // idx_q is always < N inside the grid, so an out-of-range cursor never matches
  always_comb begin
    hit_cur = cur_en_q && 32'(idx_q) == 32'(cur_idx_q) && border_q;
    rgb_d   = pass_q                      ? rgb_q :
              hit_cur                     ? COLOR_CUR :
              (win_q[idx_q] && !blink_q)  ? rgb_q :
              occ_q[idx_q]                ? (own_q[idx_q] ? COLOR_P1 : COLOR_P0) :
                                            rgb_q;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_q;
      hsync_out  <= hsync_q;
      hblnk_out  <= hblnk_q;
      vcount_out <= vcount_q;
      vsync_out  <= vsync1_q;
      vblnk_out  <= vblnk_q;
      rgb_out    <= rgb_d;
    end
  end
endmodule

// File: tb/tb_draw_cell_overlay.sv
// tb_draw_cell_overlay: directed checks of fills, cursor border, blink, shadowing and pass-through
module tb_draw_cell_overlay;
  logic        pclk = 1'b0, rst = 1'b1;
  logic [10:0] hcount_in = 11'd400, vcount_in = 11'd300;
  logic        hsync_in = 1'b1, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = 12'habc;
  logic        start_en = 1'b1, choice_en = 1'b0, cursor_en = 1'b0;
  logic [8:0]  cell_occ = '0, cell_owner = '0, win_mask = '0;
  logic [3:0]  cursor_idx = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  int checks = 0, failures = 0;
  always #5 pclk = ~pclk;
  draw_cell_overlay #(.BLINK_FRAMES(2)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en),
    .cell_occ(cell_occ), .cell_owner(cell_owner), .win_mask(win_mask),
    .cursor_en(cursor_en), .cursor_idx(cursor_idx),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // drive one pixel now (just after an edge) and check its colour two cycles later
  task automatic pix(input string tag, input int h, input int v, input logic [11:0] rgb,
                     input logic [11:0] exp);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = rgb;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    chk(tag, rgb_out, exp);
  endtask
  task automatic vs_pulse();
    hcount_in = 11'd0;
    vcount_in = 11'd780;
    vsync_in  = 1'b1;
    vblnk_in  = 1'b1;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    vsync_in = 1'b0;
    vblnk_in = 1'b0;
    @(posedge pclk);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_rgb", rgb_out, 12'h000);
    chk("rst_hcount", {1'b0, hcount_out}, 12'h000);
    chk("rst_vcount", {1'b0, vcount_out}, 12'h000);
    chk("rst_hsync", {11'b0, hsync_out}, 12'h000);
    rst      = 1'b0;
    hsync_in = 1'b0;
    pix("post_rst_rgb", 100, 100, 12'h123, 12'h123);
    chk("post_rst_hcount", {1'b0, hcount_out}, 12'd100);
    chk("post_rst_vcount", {1'b0, vcount_out}, 12'd100);
    cell_occ = 9'h010;
    pix("occ_before_vsync", 400, 300, 12'h555, 12'h555);
    vs_pulse();
    pix("fill_p0", 400, 300, 12'h555, 12'h00f);
    pix("empty_cell", 300, 300, 12'h556, 12'h556);
    cursor_en  = 1'b1;
    cursor_idx = 4'd4;
    vs_pulse();
    pix("cur_left_edge", 341, 300, 12'h111, 12'h0f0);
    pix("cur_border_4", 345, 300, 12'h112, 12'h0f0);
    pix("cur_inside_fill", 346, 300, 12'h113, 12'h00f);
    pix("col0_last_px", 340, 300, 12'h114, 12'h114);
    pix("cur_right_edge", 681, 300, 12'h115, 12'h0f0);
    pix("cur_right_inner", 677, 300, 12'h116, 12'h0f0);
    pix("cur_top_edge", 400, 259, 12'h117, 12'h0f0);
    choice_en = 1'b1;
    pix("choice_pass", 400, 300, 12'h221, 12'h221);
    choice_en = 1'b0;
    hblnk_in  = 1'b1;
    pix("hblnk_pass", 400, 300, 12'h222, 12'h222);
    hblnk_in  = 1'b0;
    start_en  = 1'b0;
    pix("nostart_pass", 400, 300, 12'h223, 12'h223);
    start_en  = 1'b1;
    cursor_idx = 4'd9;
    vs_pulse();
    pix("cursor_oob", 341, 300, 12'h331, 12'h00f);
    pix("right_of_grid", 1023, 300, 12'h332, 12'h332);
    pix("above_grid", 400, 9, 12'h333, 12'h333);
    pix("below_grid", 400, 757, 12'h334, 12'h334);
    cell_occ = 9'h100;
    cell_owner = 9'h100;
    pix("last_row_in", 1022, 756, 12'h335, 12'h335);
    pix("midframe_hold", 400, 300, 12'h441, 12'h00f);
    vs_pulse();
    pix("after_vsync_clear", 400, 300, 12'h442, 12'h442);
    pix("p1_corner_cell", 1022, 756, 12'h443, 12'hff0);
    rst = 1'b1;
    @(posedge pclk);
    #1;
    rst        = 1'b0;
    cursor_en  = 1'b0;
    cell_occ   = 9'h007;
    cell_owner = 9'h007;
    win_mask   = 9'h017;
    pix("blink_f0", 100, 100, 12'h500, 12'h500);
    for (int f = 1; f <= 5; f++) begin
      vs_pulse();
      pix($sformatf("blink_f%0d", f), 100, 100, 12'(12'h500 + f),
          (f == 2 || f == 3) ? 12'hff0 : 12'(12'h500 + f));
      pix($sformatf("win_empty_f%0d", f), 400, 300, 12'(12'h600 + f), 12'(12'h600 + f));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
